// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: req/ack data-memory handshake with pipeline stall,
// timeout abort and load extension. Optional misaligned-access trap: LSU_MISALIGN_TRAP_EN.
module mem_stage_lsu #(
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead_mem,
  input  logic        MemWrite_mem,
  input  logic [2:0]  funct3_mem,
  input  logic [31:0] ALUResult_mem,
  input  logic [31:0] WriteData_mem,
  output logic [31:0] MemDout_mem,
  output logic        stall_mem,
  output logic        bus_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic        misalign_exc
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             access, start_req, take_ack, timeout, trap, stall_c;

  logic             we_p1;
  logic [31:0]      addr_p1;
  logic [3:0]       be_p1;
  logic [31:0]      wdata_p1;
  logic [2:0]       f3_p1;
  logic [1:0]       off_p1;

  function automatic logic [3:0] byte_enable(input logic [2:0] f3, input logic [1:0] o);
    case (f3[1:0])
      2'b00:   byte_enable = 4'b0001 << o;
      2'b01:   byte_enable = o[1] ? 4'b1100 : 4'b0011;
      default: byte_enable = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   store_lanes = {4{wd[7:0]}};
      2'b01:   store_lanes = {2{wd[15:0]}};
      default: store_lanes = wd;
    endcase
  endfunction

  // Reserved funct3 codes fall through to a full-word return.
  function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [2:0] f3,
                                              input logic [1:0] o);
    logic [31:0]        lane;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] s;
    lane = (f3[1:0] == 2'b00) ? (w >> {o, 3'b000}) : (o[1] ? (w >> 16) : w);
    b    = lane[7:0];
    h    = lane[15:0];
    case (f3)
      3'b000:  s = 32'(b);
      3'b001:  s = 32'(h);
      3'b100:  s = {24'b0, lane[7:0]};
      3'b101:  s = {16'b0, lane[15:0]};
      default: s = w;
    endcase
    load_extend = s;
  endfunction

  assign access = MemRead_mem | MemWrite_mem;

`ifdef LSU_MISALIGN_TRAP_EN
  logic misaligned;
  always_comb begin
    case (funct3_mem[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = ALUResult_mem[0];
      default: misaligned = |ALUResult_mem[1:0];
    endcase
  end
`endif

  always_comb begin
    state_nxt = state;
    stall_c   = 1'b0;
    dmem_req  = 1'b0;
    start_req = 1'b0;
    take_ack  = 1'b0;
    timeout   = 1'b0;
    trap      = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          stall_c = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
          if (misaligned) begin
            trap      = 1'b1;
            state_nxt = DONE;
          end else begin
            start_req = 1'b1;
            state_nxt = REQ;
          end
`else
          start_req = 1'b1;
          state_nxt = REQ;
`endif
        end
      end
      REQ: begin
        dmem_req = 1'b1;
        stall_c  = 1'b1;
        if (dmem_ack) begin
          take_ack  = 1'b1;
          state_nxt = DONE;
        end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          timeout   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Reset drops the stall in the same cycle, even while the EX/MEM request is still asserted.
  assign stall_mem  = stall_c & rst_n;

  assign dmem_we    = we_p1;
  assign dmem_addr  = addr_p1;
  assign dmem_be    = be_p1;
  assign dmem_wdata = wdata_p1;

  // Stage p1: request fields captured on IDLE->REQ and held until the access ends.
  always_ff @(posedge clk) begin
    if (start_req) begin
      we_p1    <= MemWrite_mem;
      addr_p1  <= {ALUResult_mem[31:2], 2'b00};
      be_p1    <= byte_enable(funct3_mem, ALUResult_mem[1:0]);
      wdata_p1 <= store_lanes(funct3_mem, WriteData_mem);
      f3_p1    <= funct3_mem;
      off_p1   <= ALUResult_mem[1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      bus_err     <= 1'b0;
      MemDout_mem <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_exc <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      bus_err <= timeout;
      if (state == REQ && !dmem_ack && !timeout)
        cnt <= cnt + CNT_W'(1);
      else
        cnt <= '0;
      if (take_ack && !we_p1)
        MemDout_mem <= load_extend(dmem_rdata, f3_p1, off_p1);
      else if (timeout || trap)
        MemDout_mem <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_exc <= trap;
`endif
    end
  end

endmodule
